// File: rtl/lcd_pkg.sv
// Shared types and constants for the OUT-path LCD display block:
// FSM encodings, HD44780 command bytes, ASCII codes and small helpers.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_IDLE,
    ST_CONV,
    ST_POS,
    ST_CHARS
  } state_e;

  typedef enum logic [2:0] {
    WR_OFF,
    WR_SETUP,
    WR_EN,
    WR_HOLD,
    WR_WAIT
  } wr_phase_e;

  localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_ENTRY     = 8'h06;
  localparam logic [7:0] CMD_LINE1     = 8'h80;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  localparam logic [3:0] LAST_INIT = 4'd3;
  localparam logic [3:0] LAST_CHAR = 4'd15;

  // Power-up command order: 8-bit/2-line, display on, clear, entry mode.
  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    logic [7:0] c;
    unique case (i)
      2'd0:    c = CMD_FUNC_8B2L;
      2'd1:    c = CMD_DISP_ON;
      2'd2:    c = CMD_CLEAR;
      default: c = CMD_ENTRY;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bin_bcd32.sv
// Sequential double-dabble: one shift-add-3 step per cycle, 32 steps.
// done pulses 33 cycles after start; bcd holds the result until the next start.
module bin_bcd32
  import lcd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] bin,
  output logic        done,
  output logic [39:0] bcd
);

  logic [31:0] sh_q, sh_d;
  logic [39:0] bcd_q, bcd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [39:0] adj;

  always_comb begin
    for (int k = 0; k < 10; k++) begin
      adj[4*k +: 4] = add3(bcd_q[4*k +: 4]);
    end
  end

  always_comb begin
    sh_d   = sh_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      sh_d   = bin;
      bcd_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      bcd_d = {adj[38:0], sh_q[31]};
      sh_d  = {sh_q[30:0], 1'b0};
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/lcd_saida_dados.sv
// Shows each OUT-instruction value as a right-justified signed decimal on line 1
// of a 16x2 HD44780 LCD. Write-only bus; all delays are counted, never polled.
module lcd_saida_dados
  import lcd_pkg::*;
#(
  parameter int PWRUP_CYC = 750000,
  parameter int EN_CYC    = 25,
  parameter int SETUP_CYC = 4,
  parameter int CMD_CYC   = 2500,
  parameter int CLR_CYC   = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valor_valido,
  input  logic [31:0] valor,
  output logic        ocupado,
  output logic [7:0]  LCD_DATA,
  output logic        LCD_RS,
  output logic        LCD_RW,
  output logic        LCD_EN
);

  localparam logic [31:0] PWRUP_LAST = 32'(PWRUP_CYC - 1);
  localparam logic [31:0] EN_LAST    = 32'(EN_CYC - 1);
  localparam logic [31:0] SETUP_LAST = 32'(SETUP_CYC - 1);
  localparam logic [31:0] CMD_LAST   = 32'(CMD_CYC - 1);
  localparam logic [31:0] CLR_LAST   = 32'(CLR_CYC - 1);

  // Handshake between the main FSM and the byte writer: wr_start is only
  // raised while the writer sits in WR_OFF, and the writer answers with a
  // one-cycle wr_done at the end of its post-write wait; the next byte is
  // then offered on the following cycle.
  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] val_q, val_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_val_q, pend_val_d;
  logic        conv_seen_q;

  wr_phase_e   ph_q, ph_d;
  logic [31:0] cnt_q, cnt_d;
  logic        en_q, en_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        clr_q, clr_d;

  logic        wr_start, wr_rs, wr_done;
  logic [7:0]  wr_byte;
  logic        pwrup_done;
  logic [31:0] wait_last;

  logic        bcd_start, bcd_done;
  logic [39:0] bcd_bus;
  logic [31:0] mag;
  logic [3:0]  msd, digit_idx, digit;
  logic [7:0]  char_byte;

  // ---------------------------------------------------------------- converter
  // 0x80000000 negates to itself, which read unsigned is the right magnitude.
  assign mag = val_q[31] ? (32'd0 - val_q) : val_q;

  bin_bcd32 u_bcd (
    .clk   (clock),
    .rst_n (reset),
    .start (bcd_start),
    .bin   (mag),
    .done  (bcd_done),
    .bcd   (bcd_bus)
  );

  // ---------------------------------------------------------------- formatter
  always_comb begin
    msd = 4'd0;
    for (int k = 1; k < 10; k++) begin
      if (bcd_bus[4*k +: 4] != 4'd0) msd = 4'(k);
    end
  end

  // Column idx maps to BCD digit 15-idx; columns 0..5 can only hold blanks or '-'.
  always_comb begin
    digit_idx = 4'd15 - idx_q;
    digit     = 4'(bcd_bus >> {digit_idx, 2'b00});
    char_byte = ASCII_SPACE;
    if (idx_q >= 4'd6 && digit_idx <= msd) begin
      char_byte = ASCII_ZERO + {4'd0, digit};
    end else if (val_q[31] && idx_q == (4'd14 - msd)) begin
      char_byte = ASCII_MINUS;
    end
  end

  // ---------------------------------------------------------------- main FSM
  assign pwrup_done = (state_q == ST_PWRUP) && (cnt_q == PWRUP_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_PWRUP;
      idx_q       <= '0;
      val_q       <= '0;
      pend_q      <= 1'b0;
      pend_val_q  <= '0;
      conv_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      val_q       <= val_d;
      pend_q      <= pend_d;
      pend_val_q  <= pend_val_d;
      conv_seen_q <= (state_q == ST_CONV);
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    val_d      = val_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    if (valor_valido && state_q != ST_IDLE) begin
      pend_d     = 1'b1;
      pend_val_d = valor;
    end
    unique case (state_q)
      ST_PWRUP: begin
        if (pwrup_done) begin
          state_d = ST_INIT;
          idx_d   = '0;
        end
      end
      ST_INIT, ST_CHARS: begin
        if (wr_done) begin
          if (idx_q == ((state_q == ST_INIT) ? LAST_INIT : LAST_CHAR)) begin
            idx_d = '0;
            // A value that arrived while busy (even this very cycle) is shown next.
            if (valor_valido || pend_q) begin
              state_d = ST_CONV;
              val_d   = valor_valido ? valor : pend_val_q;
              pend_d  = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      ST_IDLE: begin
        if (valor_valido) begin
          state_d = ST_CONV;
          val_d   = valor;
        end
      end
      ST_CONV: begin
        if (bcd_done) state_d = ST_POS;
      end
      ST_POS: begin
        if (wr_done) begin
          state_d = ST_CHARS;
          idx_d   = '0;
        end
      end
      default: state_d = ST_PWRUP;
    endcase
  end

  always_comb begin
    ocupado   = (state_q != ST_IDLE);
    bcd_start = (state_q == ST_CONV) && !conv_seen_q;
    wr_start  = 1'b0;
    wr_byte   = 8'h00;
    wr_rs     = 1'b0;
    if (ph_q == WR_OFF) begin
      unique case (state_q)
        ST_INIT: begin
          wr_start = 1'b1;
          wr_byte  = init_cmd(idx_q[1:0]);
        end
        ST_POS: begin
          wr_start = 1'b1;
          wr_byte  = CMD_LINE1;
        end
        ST_CHARS: begin
          wr_start = 1'b1;
          wr_byte  = char_byte;
          wr_rs    = 1'b1;
        end
        default: wr_start = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------- byte writer
  // The shared counter also times the power-up wait while the writer is idle.
  assign wait_last = clr_q ? CLR_LAST : CMD_LAST;

  always_comb begin
    ph_d    = ph_q;
    cnt_d   = cnt_q + 32'd1;
    en_d    = en_q;
    rs_d    = rs_q;
    data_d  = data_q;
    clr_d   = clr_q;
    wr_done = 1'b0;
    unique case (ph_q)
      WR_OFF: begin
        cnt_d = '0;
        if (wr_start) begin
          ph_d   = WR_SETUP;
          data_d = wr_byte;
          rs_d   = wr_rs;
          clr_d  = !wr_rs && (wr_byte == CMD_CLEAR);
        end else if (state_q == ST_PWRUP && !pwrup_done) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      WR_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          ph_d  = WR_EN;
          en_d  = 1'b1;
          cnt_d = '0;
        end
      end
      WR_EN: begin
        if (cnt_q == EN_LAST) begin
          ph_d  = WR_HOLD;
          en_d  = 1'b0;
          cnt_d = '0;
        end
      end
      WR_HOLD: begin
        if (cnt_q == SETUP_LAST) begin
          ph_d  = WR_WAIT;
          cnt_d = '0;
        end
      end
      WR_WAIT: begin
        if (cnt_q == wait_last) begin
          ph_d    = WR_OFF;
          cnt_d   = '0;
          wr_done = 1'b1;
        end
      end
      default: begin
        ph_d  = WR_OFF;
        en_d  = 1'b0;
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ph_q   <= WR_OFF;
      cnt_q  <= '0;
      en_q   <= 1'b0;
      rs_q   <= 1'b0;
      data_q <= 8'h00;
      clr_q  <= 1'b0;
    end else begin
      ph_q   <= ph_d;
      cnt_q  <= cnt_d;
      en_q   <= en_d;
      rs_q   <= rs_d;
      data_q <= data_d;
      clr_q  <= clr_d;
    end
  end

  assign LCD_EN   = en_q;
  assign LCD_RS   = rs_q;
  assign LCD_DATA = data_q;
  assign LCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_saida_dados.sv
// Directed bench for lcd_saida_dados with shortened timing parameters.
// A bus monitor records every EN pulse as {RS, DATA} and checks its timing.
module tb_lcd_saida_dados;

  localparam int PWRUP_CYC = 20;
  localparam int EN_CYC    = 2;
  localparam int SETUP_CYC = 1;
  localparam int CMD_CYC   = 5;
  localparam int CLR_CYC   = 10;

  logic        clk;
  logic        rst_n;
  logic        valor_valido;
  logic [31:0] valor;
  logic        ocupado;
  logic [7:0]  LCD_DATA;
  logic        LCD_RS;
  logic        LCD_RW;
  logic        LCD_EN;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [8:0] obs_q[$];
  int         rise_q[$];
  logic [8:0] exp_q[$];

  lcd_saida_dados #(
    .PWRUP_CYC (PWRUP_CYC),
    .EN_CYC    (EN_CYC),
    .SETUP_CYC (SETUP_CYC),
    .CMD_CYC   (CMD_CYC),
    .CLR_CYC   (CLR_CYC)
  ) dut (
    .clock        (clk),
    .reset        (rst_n),
    .valor_valido (valor_valido),
    .valor        (valor),
    .ocupado      (ocupado),
    .LCD_DATA     (LCD_DATA),
    .LCD_RS       (LCD_RS),
    .LCD_RW       (LCD_RW),
    .LCD_EN       (LCD_EN)
  );

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- bus monitor
  bit         prev_en = 1'b0;
  logic [8:0] prev_bus = '0;
  logic [8:0] cur_bus;
  int         stable_cnt = 0;
  int         width = 0;
  int         hold_left = 0;

  always @(negedge clk) begin
    cur_bus = {LCD_RS, LCD_DATA};
    n_cmp++;
    if (LCD_RW !== 1'b0) begin
      n_fail++;
      $display("FAIL lcd_rw: got %b want 0 at cycle %0d", LCD_RW, cyc);
    end
    if (!rst_n) begin
      prev_en    = 1'b0;
      stable_cnt = 0;
      width      = 0;
      hold_left  = 0;
    end else begin
      if (prev_en || hold_left > 0) begin
        n_cmp++;
        if (cur_bus !== prev_bus) begin
          n_fail++;
          $display("FAIL bus_stable: got %h want %h at cycle %0d", cur_bus, prev_bus, cyc);
        end
      end
      if (hold_left > 0) hold_left--;
      if (cur_bus === prev_bus) stable_cnt++;
      else stable_cnt = 0;
      if (LCD_EN === 1'b1 && !prev_en) begin
        n_cmp++;
        if (stable_cnt < SETUP_CYC) begin
          n_fail++;
          $display("FAIL en_setup: got %0d stable cycles want >= %0d", stable_cnt, SETUP_CYC);
        end
        obs_q.push_back(cur_bus);
        rise_q.push_back(cyc);
        width = 1;
      end else if (LCD_EN === 1'b1) begin
        width++;
      end else if (prev_en) begin
        n_cmp++;
        if (width != EN_CYC) begin
          n_fail++;
          $display("FAIL en_width: got %0d want %0d", width, EN_CYC);
        end
        hold_left = SETUP_CYC;
      end
    end
    prev_en  = (LCD_EN === 1'b1);
    prev_bus = cur_bus;
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic strobe(input logic [31:0] v);
    @(negedge clk);
    valor_valido = 1'b1;
    valor        = v;
    @(negedge clk);
    valor_valido = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit ok);
    int i = 0;
    while (obs_q.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int i = 0;
    while (ocupado !== 1'b0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    ok = (ocupado === 1'b0);
  endtask

  task automatic push_init();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h006);
  endtask

  task automatic push_frame(input string s);
    exp_q.push_back(9'h080);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, 8'(s[i])});
  endtask

  task automatic clear_obs();
    obs_q.delete();
    rise_q.delete();
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------- scenarios
  task automatic test_reset();
    rst_n        = 1'b0;
    valor_valido = 1'b0;
    valor        = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (LCD_EN !== 1'b0) begin n_fail++; $display("FAIL rst_en: got %b want 0", LCD_EN); end
    n_cmp++;
    if (LCD_RS !== 1'b0) begin n_fail++; $display("FAIL rst_rs: got %b want 0", LCD_RS); end
    n_cmp++;
    if (LCD_DATA !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h want 00", LCD_DATA); end
    n_cmp++;
    if (ocupado !== 1'b1) begin n_fail++; $display("FAIL rst_ocupado: got %b want 1", ocupado); end
    clear_obs();
    rst_n = 1'b1;
  endtask

  task automatic test_init();
    bit ok;
    push_init();
    wait_bytes(4, 400, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL init_count: got %0d bytes want 4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL init_byte[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    if (ok) begin
      n_cmp++;
      if (rise_q[3] - rise_q[2] < CLR_CYC) begin
        n_fail++;
        $display("FAIL clear_gap: got %0d want >= %0d", rise_q[3] - rise_q[2], CLR_CYC);
      end
    end
    n_cmp++;
    if (ocupado !== 1'b1) begin n_fail++; $display("FAIL init_busy: got %b want 1", ocupado); end
    wait_idle(200, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL init_idle: got ocupado %b want 0", ocupado); end
  endtask

  task automatic test_display(input string name, input logic [31:0] v, input string s);
    bit ok;
    clear_obs();
    push_frame(s);
    strobe(v);
    n_cmp++;
    if (ocupado !== 1'b1) begin n_fail++; $display("FAIL %s_busy: got %b want 1", name, ocupado); end
    wait_bytes(17, 1000, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL %s_count: got %0d bytes want 17", name, obs_q.size()); end
    for (int i = 0; i < 17 && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_byte[%0d]: got %h want %h", name, i, obs_q[i], exp_q[i]);
      end
    end
    wait_idle(200, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL %s_idle: got ocupado %b want 0", name, ocupado); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int i = 0;
    int idle_seen = 0;
    clear_obs();
    push_frame("               5");
    push_frame("               9");
    strobe(32'd5);
    wait_bytes(5, 1000, ok);
    strobe(32'd7);
    strobe(32'd9);
    while (obs_q.size() < 34 && i < 2000) begin
      @(negedge clk);
      if (ocupado !== 1'b1) idle_seen++;
      i++;
    end
    n_cmp++;
    if (obs_q.size() < 34) begin n_fail++; $display("FAIL b2b_count: got %0d bytes want 34", obs_q.size()); end
    for (int k = 0; k < 34 && k < obs_q.size(); k++) begin
      n_cmp++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL b2b_byte[%0d]: got %h want %h", k, obs_q[k], exp_q[k]);
      end
    end
    n_cmp++;
    if (idle_seen != 0) begin n_fail++; $display("FAIL b2b_no_idle: got %0d idle cycles want 0", idle_seen); end
    wait_idle(200, ok);
    n_cmp++;
    if (!ok || obs_q.size() != 34) begin
      n_fail++;
      $display("FAIL b2b_end: got %0d bytes idle=%b want 34 idle=1", obs_q.size(), ok);
    end
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    int i = 0;
    clear_obs();
    strobe(32'd42);
    while (!(obs_q.size() >= 3 && LCD_EN === 1'b1) && i < 1000) begin
      @(negedge clk);
      i++;
    end
    n_cmp++;
    if (LCD_EN !== 1'b1) begin n_fail++; $display("FAIL mid_reach_en: got %b want 1", LCD_EN); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (LCD_EN !== 1'b0) begin n_fail++; $display("FAIL mid_async_en: got %b want 0", LCD_EN); end
    n_cmp++;
    if (ocupado !== 1'b1) begin n_fail++; $display("FAIL mid_ocupado: got %b want 1", ocupado); end
    n_cmp++;
    if ({LCD_RS, LCD_DATA} !== 9'h000) begin
      n_fail++;
      $display("FAIL mid_bus: got %h want 000", {LCD_RS, LCD_DATA});
    end
    @(negedge clk);
    clear_obs();
    push_init();
    push_frame("               3");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    strobe(32'd3);
    n_cmp++;
    if (ocupado !== 1'b1) begin n_fail++; $display("FAIL pwrup_busy: got %b want 1", ocupado); end
    wait_bytes(21, 1500, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL restart_count: got %0d bytes want 21", obs_q.size()); end
    for (int k = 0; k < 21 && k < obs_q.size(); k++) begin
      n_cmp++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL restart_byte[%0d]: got %h want %h", k, obs_q[k], exp_q[k]);
      end
    end
    wait_idle(200, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL restart_idle: got ocupado %b want 0", ocupado); end
  endtask

  // ---------------------------------------------------------------- sequence + report
  initial begin
    test_reset();
    test_init();
    test_display("v1234", 32'd1234,       "            1234");
    test_display("vneg1", 32'hFFFF_FFFF,  "              -1");
    test_display("vmin",  32'h8000_0000,  "     -2147483648");
    test_display("vzero", 32'd0,          "               0");
    test_display("vumax", 32'd4294967295, "              -1");
    test_display("vmax",  32'h7FFF_FFFF,  "      2147483647");
    test_back_to_back();
    test_reset_mid_write();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
